control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter-free interface; encodings below are fixed.
REQ-002 clock  in  1  single clock, all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 opcode  in  6  instruction bits [31:26] from instruction register.
REQ-005 funct  in  6  instruction bits [5:0] from instruction register.
REQ-006 zero  in  1  ALU zero flag, combinational from ALU.
REQ-007 pc_write, ir_write, ab_write, alu_out_write, reg_write, mem_write  out  1 each  register/memory write enables.
REQ-008 iord  out  1  memory address select: 0 PC, 1 ALUOut.
REQ-009 reg_dst  out  1  0 rt, 1 rd;  mem_to_reg  out  1  0 ALUOut, 1 MDR.
REQ-010 alu_src_a  out  1  0 PC, 1 A;  alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-011 alu_sel  out  3  ALU operation: 000 load-A, 001 add, 010 sub, 011 and, 111 compare.
REQ-012 pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target {PC[31:28], instr[25:0], 2'b00}.
REQ-013 state  out  4  current state code, debug visibility.

Function
REQ-014 Moore FSM; every output SHALL be a function of state only, except pc_write in BRANCH.
REQ-015 States/codes: RESET 0, FETCH 1, FETCH_WAIT 2, DECODE 3, EXEC_R 4, WB_R 5, EXEC_I 6, WB_I 7, ADDR 8, LW_WAIT1 9, LW_WAIT2 10, LW_WB 11, SW 12, BRANCH 13, JUMP 14; code 15 unused, SHALL go to RESET.
REQ-016 Unlisted outputs in any state SHALL be 0.
REQ-017 RESET: all outputs 0; next FETCH.
REQ-018 FETCH: iord=0; next FETCH_WAIT (memory read latency one cycle).
REQ-019 FETCH_WAIT: ir_write=1, alu_src_a=0, alu_src_b=01, alu_sel=001, pc_src=00, pc_write=1; next DECODE.
REQ-020 DECODE: ab_write=1, alu_src_a=0, alu_src_b=11, alu_sel=001, alu_out_write=1 (branch target precompute); next by opcode: 0x00 EXEC_R, 0x08 EXEC_I, 0x23/0x2b ADDR, 0x04/0x05 BRANCH, 0x02 JUMP, any other FETCH.
REQ-021 EXEC_R: alu_src_a=1, alu_src_b=00, alu_out_write=1, alu_sel by funct: 0x20 001, 0x24 011, 0x22 010; next WB_R; unsupported funct SHALL go to FETCH with alu_out_write=0.
REQ-022 WB_R: reg_dst=1, mem_to_reg=0, reg_write=1; next FETCH.
REQ-023 EXEC_I: alu_src_a=1, alu_src_b=10, alu_sel=001, alu_out_write=1; next WB_I.
REQ-024 WB_I: reg_dst=0, mem_to_reg=0, reg_write=1; next FETCH.
REQ-025 ADDR: alu_src_a=1, alu_src_b=10, alu_sel=001, alu_out_write=1; next LW_WAIT1 if opcode 0x23, SW if 0x2b.
REQ-026 LW_WAIT1, LW_WAIT2: iord=1; next LW_WAIT2, LW_WB respectively.
REQ-027 LW_WB: iord=1, reg_dst=0, mem_to_reg=1, reg_write=1; next FETCH.
REQ-028 SW: iord=1, mem_write=1; next FETCH.
REQ-029 BRANCH: alu_src_a=1, alu_src_b=00, alu_sel=010, pc_src=01; pc_write=zero for 0x04, ~zero for 0x05; next FETCH.
REQ-030 JUMP: pc_src=10, pc_write=1; next FETCH.
REQ-031 Cycle counts from FETCH entry to next FETCH entry: R/addi/sw 5, lw 7, beq/bne/j 4, unknown opcode 3.
REQ-032 opcode/funct SHALL be sampled only in DECODE, EXEC_R, ADDR, BRANCH; changes elsewhere ignored.

Reset
REQ-033 reset high at a rising edge SHALL force state=RESET in any state, mid-instruction included; outputs 0 the following cycle.
REQ-034 Reset held multiple cycles SHALL keep RESET; first cycle after release in RESET, then FETCH.
REQ-035 An interrupted sw/lw SHALL assert no mem_write/reg_write after reset edge.

Verification
REQ-036 Reset, release, opcode=0x00 funct=0x20 -> states 0,1,2,3,4,5,1; EXEC_R alu_sel=001; WB_R reg_write=1 reg_dst=1.
REQ-037 opcode=0x23 -> states 1,2,3,8,9,10,11,1; LW_WB mem_to_reg=1, reg_write=1; mem_write never 1.
REQ-038 opcode=0x04 zero=1 -> BRANCH pc_write=1 pc_src=01; opcode=0x05 zero=1 -> pc_write=0.
REQ-039 opcode=0x3f -> states 1,2,3,1, no reg_write/mem_write; funct=0x00 R-type -> 1,2,3,4,1.
REQ-040 reset asserted in SW state (12) -> next cycle state=0, mem_write=0; then state 1.

Source files
------------

// File: rtl/control_unit.sv
// Multi-cycle MIPS-style control unit.
// Moore FSM: every control output is registered alongside the state, so the
// outputs seen in a cycle belong to the state held in that cycle. The only
// combinational output path is pc_write in BRANCH, which depends on the
// ALU zero flag computed during that same cycle.
//
// There are no valid/ready handshakes in this block. Instruction fields are
// treated as stable from the instruction register. opcode is consulted only
// when leaving DECODE and ADDR, and while in BRANCH. funct is consulted when
// leaving DECODE (to pick the EXEC_R ALU operation) and when leaving EXEC_R.
module control_unit (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_write,
    output logic       ir_write,
    output logic       ab_write,
    output logic       alu_out_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       iord,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_sel,
    output logic [1:0] pc_src,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RESET      = 4'd0,
        S_FETCH      = 4'd1,
        S_FETCH_WAIT = 4'd2,
        S_DECODE     = 4'd3,
        S_EXEC_R     = 4'd4,
        S_WB_R       = 4'd5,
        S_EXEC_I     = 4'd6,
        S_WB_I       = 4'd7,
        S_ADDR       = 4'd8,
        S_LW_WAIT1   = 4'd9,
        S_LW_WAIT2   = 4'd10,
        S_LW_WB      = 4'd11,
        S_SW         = 4'd12,
        S_BRANCH     = 4'd13,
        S_JUMP       = 4'd14,
        S_UNUSED     = 4'd15
    } state_t;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type function codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    // ALU operations
    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;

    // ALU B-operand selects
    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // PC source selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       ab_write;
        logic       alu_out_write;
        logic       reg_write;
        logic       mem_write;
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_sel;
        logic [1:0] pc_src;
    } ctrl_t;

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl_d;
    logic   funct_ok;
    logic   branch_take;

    // Only add, sub and and are executed; anything else aborts the R-type.
    assign funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND);

    // Next-state selection from the current state and the instruction fields.
    always_comb begin
        state_d = S_RESET;
        case (state_q)
            S_RESET:      state_d = S_FETCH;
            S_FETCH:      state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC_R;
                    OP_ADDI:      state_d = S_EXEC_I;
                    OP_LW, OP_SW: state_d = S_ADDR;
                    OP_BEQ,
                    OP_BNE:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_EXEC_R:     state_d = funct_ok ? S_WB_R : S_FETCH;
            S_WB_R:       state_d = S_FETCH;
            S_EXEC_I:     state_d = S_WB_I;
            S_WB_I:       state_d = S_FETCH;
            S_ADDR: begin
                if (opcode == OP_LW)
                    state_d = S_LW_WAIT1;
                else if (opcode == OP_SW)
                    state_d = S_SW;
                else
                    state_d = S_FETCH;
            end
            S_LW_WAIT1:   state_d = S_LW_WAIT2;
            S_LW_WAIT2:   state_d = S_LW_WB;
            S_LW_WB:      state_d = S_FETCH;
            S_SW:         state_d = S_FETCH;
            S_BRANCH:     state_d = S_FETCH;
            S_JUMP:       state_d = S_FETCH;
            default:      state_d = S_RESET;
        endcase
    end

    // Control word for the state about to be entered; registered with it.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_FETCH: begin
                ctrl_d.iord = 1'b0;
            end
            S_FETCH_WAIT: begin
                ctrl_d.ir_write  = 1'b1;
                ctrl_d.alu_src_a = 1'b0;
                ctrl_d.alu_src_b = SRCB_FOUR;
                ctrl_d.alu_sel   = ALU_ADD;
                ctrl_d.pc_src    = PCSRC_ALU;
                ctrl_d.pc_write  = 1'b1;
            end
            S_DECODE: begin
                // Branch target is precomputed here while A/B are loaded.
                ctrl_d.ab_write      = 1'b1;
                ctrl_d.alu_src_a     = 1'b0;
                ctrl_d.alu_src_b     = SRCB_IMMSH;
                ctrl_d.alu_sel       = ALU_ADD;
                ctrl_d.alu_out_write = 1'b1;
            end
            S_EXEC_R: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = SRCB_B;
                case (funct)
                    FN_ADD: ctrl_d.alu_sel = ALU_ADD;
                    FN_SUB: ctrl_d.alu_sel = ALU_SUB;
                    FN_AND: ctrl_d.alu_sel = ALU_AND;
                    default: ctrl_d.alu_sel = ALU_PASS;
                endcase
                // An unsupported funct must not disturb ALUOut.
                ctrl_d.alu_out_write = funct_ok;
            end
            S_WB_R: begin
                ctrl_d.reg_dst    = 1'b1;
                ctrl_d.mem_to_reg = 1'b0;
                ctrl_d.reg_write  = 1'b1;
            end
            S_EXEC_I, S_ADDR: begin
                ctrl_d.alu_src_a     = 1'b1;
                ctrl_d.alu_src_b     = SRCB_IMM;
                ctrl_d.alu_sel       = ALU_ADD;
                ctrl_d.alu_out_write = 1'b1;
            end
            S_WB_I: begin
                ctrl_d.reg_dst    = 1'b0;
                ctrl_d.mem_to_reg = 1'b0;
                ctrl_d.reg_write  = 1'b1;
            end
            S_LW_WAIT1, S_LW_WAIT2: begin
                ctrl_d.iord = 1'b1;
            end
            S_LW_WB: begin
                ctrl_d.iord       = 1'b1;
                ctrl_d.reg_dst    = 1'b0;
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.reg_write  = 1'b1;
            end
            S_SW: begin
                ctrl_d.iord      = 1'b1;
                ctrl_d.mem_write = 1'b1;
            end
            S_BRANCH: begin
                // pc_write is resolved combinationally from zero below.
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = SRCB_B;
                ctrl_d.alu_sel   = ALU_SUB;
                ctrl_d.pc_src    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl_d.pc_src   = PCSRC_JUMP;
                ctrl_d.pc_write = 1'b1;
            end
            default: ctrl_d = '0;
        endcase
    end

    // State and control word registers; reset wins in every state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_RESET;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Branch decision: beq takes on zero, bne on not-zero.
    always_comb begin
        branch_take = 1'b0;
        if (state_q == S_BRANCH) begin
            if (opcode == OP_BEQ)
                branch_take = zero;
            else if (opcode == OP_BNE)
                branch_take = ~zero;
        end
    end

    assign pc_write      = ctrl_q.pc_write | branch_take;
    assign ir_write      = ctrl_q.ir_write;
    assign ab_write      = ctrl_q.ab_write;
    assign alu_out_write = ctrl_q.alu_out_write;
    assign reg_write     = ctrl_q.reg_write;
    assign mem_write     = ctrl_q.mem_write;
    assign iord          = ctrl_q.iord;
    assign reg_dst       = ctrl_q.reg_dst;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign alu_sel       = ctrl_q.alu_sel;
    assign pc_src        = ctrl_q.pc_src;
    assign state         = state_q;

endmodule
